text_mode_display_controller: RTL and testbench

Parametrised text-mode VGA controller, successor to the single-character display path. Generates H/V timing from parameters and holds a COLS x ROWS text buffer with per-cell foreground/background colour. The buffer is written through a valid/ready port. It fetches glyph rows from an external synchronous font ROM and overlays a blinking cursor. It sits between the system bus / keyboard logic and the VGA connector.

---
 rtl/text_mode_display_controller.sv | 273 +++++++++++++++++++++++++++
 tb/tb_text_mode_display_controller.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_mode_display_controller.sv
// Text-mode VGA controller: sync timing, COLS x ROWS character/colour buffer,
// external font ROM fetch, blinking cursor overlay and a valid/ready write port.
//
// Ports:
//   Pixelclock   pixel clock (only clock)
//   reset        asynchronous active-low reset
//   wr_valid     text buffer write request
//   wr_ready     write accepted on this edge when high with wr_valid
//   wr_addr      cell index, row*COLS+col (out-of-range writes are dropped)
//   wr_char      character code
//   wr_fg/wr_bg  foreground/background colour {R,G,B}
//   cursor_en    cursor overlay enable
//   cursor_addr  cursor cell index
//   glyph_addr   {char, glyph row} to the font ROM
//   glyph_bits   font ROM row, one cycle after glyph_addr, MSB = leftmost pixel
//   HSYNC/VSYNC  sync outputs, active level SYNC_POL
//   RGB_out      pixel colour, 4 cycles behind the h/v counters
//   frame_start  pulse with pixel (0,0) on RGB_out
module text_mode_display_controller #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int SYNC_POL     = 0,
    parameter int GLYPH_W      = 8,
    parameter int GLYPH_H      = 16,
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int CW           = 3,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                              Pixelclock,
    input  logic                              reset,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [$clog2(COLS*ROWS)-1:0]      wr_addr,
    input  logic [7:0]                        wr_char,
    input  logic [3*CW-1:0]                   wr_fg,
    input  logic [3*CW-1:0]                   wr_bg,
    input  logic                              cursor_en,
    input  logic [$clog2(COLS*ROWS)-1:0]      cursor_addr,
    output logic [8+$clog2(GLYPH_H)-1:0]      glyph_addr,
    input  logic [GLYPH_W-1:0]                glyph_bits,
    output logic                              HSYNC,
    output logic                              VSYNC,
    output logic [3*CW-1:0]                   RGB_out,
    output logic                              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CELLS   = COLS * ROWS;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(CELLS);
    localparam int GRW     = $clog2(GLYPH_H);
    localparam int PW      = 3 * CW;
    localparam int BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_LO  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_HI  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] H_TXT  = HW'(COLS * GLYPH_W);
    localparam logic [HW-1:0] H_GW   = HW'(GLYPH_W);

    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_LO  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_HI  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] V_TXT  = VW'(ROWS * GLYPH_H);
    localparam logic [VW-1:0] V_GH   = VW'(GLYPH_H);

    localparam logic [AW-1:0] COLS_A  = AW'(COLS);
    localparam logic [AW:0]   CELLS_X = (AW+1)'(CELLS);
    localparam logic [BW-1:0] B_LAST  = BW'(BLINK_FRAMES - 1);
    localparam logic          POL     = (SYNC_POL != 0);

    // ---------------- timing counters ----------------
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          h_wrap;
    logic          v_wrap;

    assign h_wrap = (h == H_LAST);
    assign v_wrap = h_wrap && (v == V_LAST);

    always_ff @(posedge Pixelclock or negedge reset) begin
        if (!reset) begin
            h <= '0;
            v <= '0;
        end else if (h_wrap) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    // ---------------- blink and frame tracking ----------------
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic          primed;

    // The frame that begins at reset release is not announced on
    // frame_start; the first pulse follows a complete vertical wrap.
    always_ff @(posedge Pixelclock or negedge reset) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            primed      <= 1'b0;
        end else if (v_wrap) begin
            primed <= 1'b1;
            if (blink_cnt == B_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // ---------------- cell addressing ----------------
    logic [HW-1:0] h_col;
    logic [HW-1:0] h_sub;
    logic [VW-1:0] v_row;
    logic [VW-1:0] v_sub;
    logic          fetch;
    logic [AW-1:0] fetch_idx;

    assign h_col     = h / H_GW;
    assign h_sub     = h % H_GW;
    assign v_row     = v / V_GH;
    assign v_sub     = v % V_GH;
    assign fetch     = (h < H_TXT) && (v < V_TXT) && (h_sub == '0);
    assign fetch_idx = AW'(v_row) * COLS_A + AW'(h_col);

    // ---------------- text RAM (single port, fetch wins) ----------------
    logic [7:0]    char_mem [CELLS];
    logic [PW-1:0] fg_mem   [CELLS];
    logic [PW-1:0] bg_mem   [CELLS];
    logic [AW-1:0] ram_addr;
    logic          wr_in_range;
    logic          wr_en;
    logic [7:0]    rd_char;
    logic [PW-1:0] rd_fg;
    logic [PW-1:0] rd_bg;

    assign wr_ready    = reset && !fetch;
    assign ram_addr    = fetch ? fetch_idx : wr_addr;
    assign wr_in_range = ({1'b0, wr_addr} < CELLS_X);
    assign wr_en       = wr_valid && wr_ready && wr_in_range;
    assign rd_char     = char_mem[ram_addr];
    assign rd_fg       = fg_mem[ram_addr];
    assign rd_bg       = bg_mem[ram_addr];

    always_ff @(posedge Pixelclock) begin
        if (wr_en) begin
            char_mem[ram_addr] <= wr_char;
            fg_mem[ram_addr]   <= wr_fg;
            bg_mem[ram_addr]   <= wr_bg;
        end
    end

    // ---------------- stage 1: glyph address + cell attributes ----------------
    logic          cur_hit;
    logic [PW-1:0] s1_fg;
    logic [PW-1:0] s1_bg;
    logic          s1_cur;
    logic          f1;
    logic          f2;

    assign cur_hit = cursor_en && blink_phase && (fetch_idx == cursor_addr);

    always_ff @(posedge Pixelclock or negedge reset) begin
        if (!reset) begin
            glyph_addr <= '0;
            s1_fg      <= '0;
            s1_bg      <= '0;
            s1_cur     <= 1'b0;
            f1         <= 1'b0;
            f2         <= 1'b0;
        end else begin
            f1 <= fetch;
            f2 <= f1;
            if (fetch) begin
                glyph_addr <= {rd_char, GRW'(v_sub)};
                s1_fg      <= rd_fg;
                s1_bg      <= rd_bg;
                s1_cur     <= cur_hit;
            end
        end
    end

    // ---------------- stage 2: glyph capture + pixel shifter ----------------
    logic [GLYPH_W-1:0] pix_sh;
    logic [PW-1:0]      s2_fg;
    logic [PW-1:0]      s2_bg;

    // glyph_bits arrives two cycles after the fetch cycle; the cursor swap
    // is resolved here so the whole cell uses one colour pair.
    always_ff @(posedge Pixelclock or negedge reset) begin
        if (!reset) begin
            pix_sh <= '0;
            s2_fg  <= '0;
            s2_bg  <= '0;
        end else if (f2) begin
            pix_sh <= glyph_bits;
            s2_fg  <= s1_cur ? s1_bg : s1_fg;
            s2_bg  <= s1_cur ? s1_fg : s1_bg;
        end else begin
            pix_sh <= {pix_sh[GLYPH_W-2:0], 1'b0};
        end
    end

    // ---------------- per-pixel flag delay (3 stages + output) ----------------
    logic       act0;
    logic       txt0;
    logic       hs0;
    logic       vs0;
    logic       fs0;
    logic [2:0] act_d;
    logic [2:0] txt_d;
    logic [2:0] hs_d;
    logic [2:0] vs_d;
    logic [2:0] fs_d;

    assign act0 = (h < H_ACT) && (v < V_ACT);
    assign txt0 = (h < H_TXT) && (v < V_TXT);
    assign hs0  = (h >= HS_LO) && (h <= HS_HI);
    assign vs0  = (v >= VS_LO) && (v <= VS_HI);
    assign fs0  = primed && (h == '0) && (v == '0);

    always_ff @(posedge Pixelclock or negedge reset) begin
        if (!reset) begin
            act_d <= '0;
            txt_d <= '0;
            hs_d  <= '0;
            vs_d  <= '0;
            fs_d  <= '0;
        end else begin
            act_d <= {act_d[1:0], act0};
            txt_d <= {txt_d[1:0], txt0};
            hs_d  <= {hs_d[1:0], hs0};
            vs_d  <= {vs_d[1:0], vs0};
            fs_d  <= {fs_d[1:0], fs0};
        end
    end

    // ---------------- output registers ----------------
    always_ff @(posedge Pixelclock or negedge reset) begin
        if (!reset) begin
            HSYNC       <= ~POL;
            VSYNC       <= ~POL;
            RGB_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            HSYNC       <= hs_d[2] ? POL : ~POL;
            VSYNC       <= vs_d[2] ? POL : ~POL;
            frame_start <= fs_d[2];
            if (act_d[2] && txt_d[2]) begin
                RGB_out <= pix_sh[GLYPH_W-1] ? s2_fg : s2_bg;
            end else begin
                RGB_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_text_mode_display_controller.sv
// Directed bench for text_mode_display_controller on a reduced 80x46 frame
// with a 6x2 text grid, font ROM model and counter model for positioning.
module tb_text_mode_display_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_char = '0;
    logic [8:0]  wr_fg = '0;
    logic [8:0]  wr_bg = '0;
    logic        cursor_en = 1'b0;
    logic [3:0]  cursor_addr = '0;
    logic [11:0] glyph_addr;
    logic [7:0]  glyph_bits = '0;
    logic        HSYNC;
    logic        VSYNC;
    logic [8:0]  RGB_out;
    logic        frame_start;

    int n_checks = 0;
    int n_pass = 0;
    int th;
    int tv;

    text_mode_display_controller #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(0), .GLYPH_W(8), .GLYPH_H(16),
        .COLS(6), .ROWS(2), .CW(3), .BLINK_FRAMES(2)
    ) dut (
        .Pixelclock(clk),
        .reset(rst_n),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr(wr_addr),
        .wr_char(wr_char),
        .wr_fg(wr_fg),
        .wr_bg(wr_bg),
        .cursor_en(cursor_en),
        .cursor_addr(cursor_addr),
        .glyph_addr(glyph_addr),
        .glyph_bits(glyph_bits),
        .HSYNC(HSYNC),
        .VSYNC(VSYNC),
        .RGB_out(RGB_out),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // font ROM: 0x41 is a fixed 1000_0001 glyph, others depend on char and row
    always @(posedge clk) begin
        if (glyph_addr[11:4] == 8'h41)
            glyph_bits <= 8'h81;
        else
            glyph_bits <= glyph_addr[11:4] ^ {glyph_addr[3:0], 4'h0};
    end

    // position of the DUT counters (80 x 46 frame)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            th <= 0;
            tv <= 0;
        end else if (th == 79) begin
            th <= 0;
            tv <= (tv == 45) ? 0 : tv + 1;
        end else begin
            th <= th + 1;
        end
    end

    task automatic goto(input int gh, input int gv);
        int n;
        n = 0;
        @(negedge clk);
        while (!(th == gh && tv == gv) && n < 8000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8000) begin
            n_checks++;
            $display("FAIL goto_timeout h=%0d v=%0d", gh, gv);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] c,
                            input logic [8:0] f, input logic [8:0] b);
        int n;
        @(negedge clk);
        wr_addr = a;
        wr_char = c;
        wr_fg = f;
        wr_bg = b;
        wr_valid = 1'b1;
        n = 0;
        while (!wr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 20) $display("FAIL write_accept addr=%0d got no ready", a);
        else n_pass++;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (HSYNC !== 1'b1) $display("FAIL rst_hsync got %b exp 1", HSYNC);
        else n_pass++;
        n_checks++;
        if (VSYNC !== 1'b1) $display("FAIL rst_vsync got %b exp 1", VSYNC);
        else n_pass++;
        n_checks++;
        if (RGB_out !== 9'h0) $display("FAIL rst_rgb got %h exp 0", RGB_out);
        else n_pass++;
        n_checks++;
        if (frame_start !== 1'b0) $display("FAIL rst_fs got %b exp 0", frame_start);
        else n_pass++;
        n_checks++;
        if (wr_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", wr_ready);
        else n_pass++;
        n_checks++;
        if (glyph_addr !== 12'h0) $display("FAIL rst_gaddr got %h exp 0", glyph_addr);
        else n_pass++;
    endtask

    task automatic test_sync();
        int hf1, hf2, hr1, vf, vr, fs;
        logic phs, pvs;
        hf1 = -1; hf2 = -1; hr1 = -1; vf = -1; vr = -1; fs = -1;
        phs = 1'b1;
        pvs = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 3700; n++) begin
            @(negedge clk);
            if (phs && !HSYNC) begin
                if (hf1 < 0) hf1 = n;
                else if (hf2 < 0) hf2 = n;
            end
            if (!phs && HSYNC && hr1 < 0) hr1 = n;
            if (pvs && !VSYNC && vf < 0) vf = n;
            if (!pvs && VSYNC && vr < 0) vr = n;
            if (frame_start && fs < 0) fs = n;
            phs = HSYNC;
            pvs = VSYNC;
        end
        n_checks++;
        if (hf1 != 72) $display("FAIL hsync_fall got %0d exp 72", hf1);
        else n_pass++;
        n_checks++;
        if (hr1 != 80) $display("FAIL hsync_rise got %0d exp 80", hr1);
        else n_pass++;
        n_checks++;
        if (hf2 != 152) $display("FAIL hsync_period got %0d exp 152", hf2);
        else n_pass++;
        n_checks++;
        if (vf != 3364) $display("FAIL vsync_fall got %0d exp 3364", vf);
        else n_pass++;
        n_checks++;
        if (vr != 3524) $display("FAIL vsync_rise got %0d exp 3524", vr);
        else n_pass++;
        n_checks++;
        if (fs != 3684) $display("FAIL first_fs got %0d exp 3684", fs);
        else n_pass++;
    endtask

    task automatic test_pixel();
        logic [8:0] exp;
        do_write(4'd0, 8'h41, 9'h1FF, 9'h000);
        goto(4, 0);
        n_checks++;
        if (glyph_addr !== 12'h410) $display("FAIL gaddr_row0 got %h exp 410", glyph_addr);
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) goto(4 + k, 0);
            exp = (k == 0 || k == 7) ? 9'h1FF : 9'h000;
            n_checks++;
            if (RGB_out !== exp) $display("FAIL pix0_%0d got %h exp %h", k, RGB_out, exp);
            else n_pass++;
        end
        goto(4, 3);
        n_checks++;
        if (glyph_addr !== 12'h413) $display("FAIL gaddr_row3 got %h exp 413", glyph_addr);
        else n_pass++;
        n_checks++;
        if (RGB_out !== 9'h1FF) $display("FAIL pix_row3 got %h exp 1ff", RGB_out);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int idx, lows, bad;
        logic acc;
        logic exp_rdy;
        logic [8:0] exp;
        idx = 0; lows = 0; bad = 0; acc = 1'b0;
        goto(0, 16);
        wr_addr = 4'd0;
        wr_char = 8'hF0;
        wr_fg = 9'h100;
        wr_bg = 9'h040;
        wr_valid = 1'b1;
        for (int c = 0; c < 48; c++) begin
            if (c > 0) @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 12) begin
                    wr_addr = 4'(idx);
                    wr_fg = 9'h100 | 9'(idx);
                    wr_bg = 9'h040 | 9'(idx);
                end else begin
                    wr_valid = 1'b0;
                end
            end
            exp_rdy = (th % 8 != 0);
            if (wr_ready !== exp_rdy) bad++;
            if (!wr_ready) lows++;
            acc = wr_valid && wr_ready;
        end
        wr_valid = 1'b0;
        n_checks++;
        if (lows != 6) $display("FAIL b2b_lows got %0d exp 6", lows);
        else n_pass++;
        n_checks++;
        if (bad != 0) $display("FAIL b2b_ready_pos got %0d exp 0", bad);
        else n_pass++;
        n_checks++;
        if (idx != 12) $display("FAIL b2b_writes got %0d exp 12", idx);
        else n_pass++;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 6; c++) begin
                goto(c * 8 + 4, r * 16);
                exp = 9'h100 | 9'(r * 6 + c);
                n_checks++;
                if (RGB_out !== exp) $display("FAIL b2b_fg%0d got %h exp %h", r * 6 + c, RGB_out, exp);
                else n_pass++;
                goto(c * 8 + 8, r * 16);
                exp = 9'h040 | 9'(r * 6 + c);
                n_checks++;
                if (RGB_out !== exp) $display("FAIL b2b_bg%0d got %h exp %h", r * 6 + c, RGB_out, exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_outside();
        goto(60, 36);
        do_write(4'd5, 8'h00, 9'h155, 9'h0AA);
        goto(51, 0);
        n_checks++;
        if (RGB_out !== 9'h0AA) $display("FAIL cell5_edge got %h exp 0aa", RGB_out);
        else n_pass++;
        goto(54, 0);
        n_checks++;
        if (RGB_out !== 9'h0) $display("FAIL right_of_text got %h exp 0", RGB_out);
        else n_pass++;
        goto(74, 0);
        n_checks++;
        if (RGB_out !== 9'h0) $display("FAIL hblank got %h exp 0", RGB_out);
        else n_pass++;
        goto(46, 3);
        n_checks++;
        if (RGB_out !== 9'h155) $display("FAIL cell5_row3 got %h exp 155", RGB_out);
        else n_pass++;
        goto(4, 36);
        n_checks++;
        if (RGB_out !== 9'h0) $display("FAIL below_text got %h exp 0", RGB_out);
        else n_pass++;
    endtask

    task automatic test_oob();
        goto(60, 36);
        wr_addr = 4'd13;
        wr_char = 8'h00;
        wr_fg = 9'h000;
        wr_bg = 9'h1FF;
        wr_valid = 1'b1;
        n_checks++;
        if (wr_ready !== 1'b1) $display("FAIL oob_ready got %b exp 1", wr_ready);
        else n_pass++;
        @(negedge clk);
        wr_valid = 1'b0;
        goto(12, 16);
        n_checks++;
        if (RGB_out !== 9'h107) $display("FAIL oob_cell7 got %h exp 107", RGB_out);
        else n_pass++;
        goto(48, 16);
        n_checks++;
        if (RGB_out !== 9'h04B) $display("FAIL oob_cell11 got %h exp 04b", RGB_out);
        else n_pass++;
    endtask

    task automatic test_midframe_reset();
        int fs;
        fs = -1;
        goto(34, 20);
        n_checks++;
        if (RGB_out !== 9'h049) $display("FAIL pre_reset_pix got %h exp 049", RGB_out);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (RGB_out !== 9'h0) $display("FAIL mid_rst_rgb got %h exp 0", RGB_out);
        else n_pass++;
        n_checks++;
        if (glyph_addr !== 12'h0) $display("FAIL mid_rst_gaddr got %h exp 0", glyph_addr);
        else n_pass++;
        n_checks++;
        if (wr_ready !== 1'b0) $display("FAIL mid_rst_ready got %b exp 0", wr_ready);
        else n_pass++;
        n_checks++;
        if (HSYNC !== 1'b1 || VSYNC !== 1'b1) $display("FAIL mid_rst_sync got %b%b exp 11", HSYNC, VSYNC);
        else n_pass++;
        n_checks++;
        if (frame_start !== 1'b0) $display("FAIL mid_rst_fs got %b exp 0", frame_start);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 4000; n++) begin
            @(negedge clk);
            if (frame_start) begin
                fs = n;
                break;
            end
        end
        n_checks++;
        if (fs != 3684) $display("FAIL restart_fs got %0d exp 3684", fs);
        else n_pass++;
        n_checks++;
        if (RGB_out !== 9'h100) $display("FAIL fs_pixel got %h exp 100", RGB_out);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (frame_start !== 1'b0) $display("FAIL fs_width got %b exp 0", frame_start);
        else n_pass++;
    endtask

    task automatic test_cursor();
        logic sw;
        logic [8:0] exp;
        @(negedge clk);
        rst_n = 1'b0;
        cursor_en = 1'b1;
        cursor_addr = 4'd7;
        @(negedge clk);
        rst_n = 1'b1;
        for (int fr = 0; fr < 5; fr++) begin
            sw = (fr == 2 || fr == 3);
            goto(12, 16);
            exp = sw ? 9'h047 : 9'h107;
            n_checks++;
            if (RGB_out !== exp) $display("FAIL cur_fg_f%0d got %h exp %h", fr, RGB_out, exp);
            else n_pass++;
            goto(16, 16);
            exp = sw ? 9'h107 : 9'h047;
            n_checks++;
            if (RGB_out !== exp) $display("FAIL cur_bg_f%0d got %h exp %h", fr, RGB_out, exp);
            else n_pass++;
            goto(20, 16);
            n_checks++;
            if (RGB_out !== 9'h108) $display("FAIL cur_next_f%0d got %h exp 108", fr, RGB_out);
            else n_pass++;
        end
        cursor_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sync();
        test_pixel();
        test_back_to_back();
        test_outside();
        test_oob();
        test_midframe_reset();
        test_cursor();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
